avaliador_noite: RTL

Datapath responder to the game's night-phase control FSM. It owns the player counter, the alive mask, per-target wolf vote tallies and the doctor's protection. It records one action per player turn and, on command, runs a multi-cycle scan that picks the eliminated player. It returns CJ_fim and jogador_vivo to the controller, and the death result to the announcer/display.

---
 rtl/avaliador_noite_if.sv | 41 ++++
 rtl/avaliador_noite.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/avaliador_noite_if.sv
// avaliador_noite_if
//   Bus between the night-phase controller (master) and the avaliador_noite
//   datapath (slave).
//   Controller -> datapath: zera_CJ, inc_jogador, processar_acao, passa,
//     classe, alvo, avaliar_eliminacao.
//   Datapath -> controller/announcer: jogador_atual, CJ_fim, jogador_vivo,
//     vivos, acao_invalida, ocupado, morte_valida, morto_id.
interface avaliador_noite_if #(
   parameter int N_JOGADORES = 8,
   parameter int W_ID        = 3
);
   logic                   zera_CJ;
   logic                   inc_jogador;
   logic                   processar_acao;
   logic                   passa;
   logic [1:0]             classe;
   logic [W_ID-1:0]        alvo;
   logic                   avaliar_eliminacao;
   logic [W_ID-1:0]        jogador_atual;
   logic                   CJ_fim;
   logic                   jogador_vivo;
   logic [N_JOGADORES-1:0] vivos;
   logic                   acao_invalida;
   logic                   ocupado;
   logic                   morte_valida;
   logic [W_ID-1:0]        morto_id;

   modport master (
      output zera_CJ, inc_jogador, processar_acao, passa, classe, alvo,
             avaliar_eliminacao,
      input  jogador_atual, CJ_fim, jogador_vivo, vivos, acao_invalida,
             ocupado, morte_valida, morto_id
   );

   modport slave (
      input  zera_CJ, inc_jogador, processar_acao, passa, classe, alvo,
             avaliar_eliminacao,
      output jogador_atual, CJ_fim, jogador_vivo, vivos, acao_invalida,
             ocupado, morte_valida, morto_id
   );
endinterface

// File: rtl/avaliador_noite.sv
// avaliador_noite
//   Night-phase datapath: player counter, alive mask, per-target wolf vote
//   tallies and doctor protection. Records one action per player turn and,
//   on avaliar_eliminacao, scans the tallies one player per cycle to pick
//   who is eliminated.
//   Ports: clock, reset (sync, active-high), rst_global (soft clear, same
//   effect), bus (avaliador_noite_if.slave, see interface header).
//   Optional: define ELIMINA_EMPATE_EN to eliminate the lowest-index target
//   on a tie at the maximum instead of sparing everyone.
module avaliador_noite #(
   parameter int N_JOGADORES = 8,
   parameter int W_ID        = 3,
   parameter int W_VOTO      = 4
) (
   input logic               clock,
   input logic               reset,
   input logic               rst_global,
   avaliador_noite_if.slave  bus
);
   typedef enum logic [1:0] {OCIOSO, VARRE, APLICA} estado_t;

   localparam logic [W_ID-1:0] ULTIMO = W_ID'(N_JOGADORES-1);

   estado_t                               st_q, st_d;
   logic [W_ID-1:0]                       cnt_q, cnt_d;
   logic [N_JOGADORES-1:0]                vivos_q, vivos_d;
   logic [N_JOGADORES-1:0][W_VOTO-1:0]    tally_q, tally_d;
   logic [W_ID-1:0]                       prot_q, prot_d;
   logic                                  prot_v_q, prot_v_d;
   logic                                  feito_q, feito_d;
   logic [W_ID-1:0]                       idx_q, idx_d;
   logic [W_VOTO-1:0]                     max_q, max_d;
   logic [W_ID-1:0]                       cand_q, cand_d;
   logic                                  empate_q, empate_d;
   logic                                  morte_q, morte_d;
   logic [W_ID-1:0]                       morto_q, morto_d;
   logic                                  inval_q, inval_d;

   logic captura, alvo_ok, elimina;

   // A turn is only open to a living player, once, and never mid-evaluation.
   assign captura = bus.processar_acao & bus.passa & ~feito_q &
                    (st_q == OCIOSO) & vivos_q[cnt_q];
   assign alvo_ok = (int'(bus.alvo) < N_JOGADORES) && vivos_q[bus.alvo];

`ifdef ELIMINA_EMPATE_EN
   // Scan keeps the first maximum, so a tie resolves to the lowest index.
   assign elimina = (max_q != '0) && !(prot_v_q && (prot_q == cand_q));
`else
   assign elimina = (max_q != '0) && !empate_q &&
                    !(prot_v_q && (prot_q == cand_q));
`endif

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      vivos_d  = vivos_q;
      tally_d  = tally_q;
      prot_d   = prot_q;
      prot_v_d = prot_v_q;
      feito_d  = feito_q;
      idx_d    = idx_q;
      max_d    = max_q;
      cand_d   = cand_q;
      empate_d = empate_q;
      morte_d  = morte_q;
      morto_d  = morto_q;
      inval_d  = 1'b0;

      if (captura) begin
         if (!alvo_ok) begin
            // Rejected: acao_feita stays clear so the player may retry.
            inval_d = 1'b1;
         end else begin
            feito_d = 1'b1;
            case (bus.classe)
               2'd1: if (tally_q[bus.alvo] != '1)
                        tally_d[bus.alvo] = tally_q[bus.alvo] + W_VOTO'(1);
               2'd2: begin
                  prot_d   = bus.alvo;
                  prot_v_d = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (bus.zera_CJ)
         cnt_d = '0;
      else if (bus.inc_jogador)
         cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + W_ID'(1);
      if (bus.inc_jogador)
         feito_d = 1'b0;

      case (st_q)
         OCIOSO: if (bus.avaliar_eliminacao) begin
            st_d     = VARRE;
            idx_d    = '0;
            max_d    = '0;
            cand_d   = '0;
            empate_d = 1'b0;
         end
         VARRE: begin
            if (tally_q[idx_q] > max_q) begin
               max_d    = tally_q[idx_q];
               cand_d   = idx_q;
               empate_d = 1'b0;
            end else if ((tally_q[idx_q] == max_q) && (max_q != '0)) begin
               empate_d = 1'b1;
            end
            if (idx_q == ULTIMO)
               st_d = APLICA;
            else
               idx_d = idx_q + W_ID'(1);
         end
         APLICA: begin
            if (elimina) begin
               vivos_d[cand_q] = 1'b0;
               morte_d         = 1'b1;
               morto_d         = cand_q;
            end else begin
               morte_d = 1'b0;
            end
            tally_d  = '0;
            prot_v_d = 1'b0;
            st_d     = OCIOSO;
         end
         default: st_d = OCIOSO;
      endcase

      // Soft clear overrides everything computed above, aborting any scan.
      if (rst_global) begin
         st_d     = OCIOSO;
         cnt_d    = '0;
         vivos_d  = '1;
         tally_d  = '0;
         prot_d   = '0;
         prot_v_d = 1'b0;
         feito_d  = 1'b0;
         idx_d    = '0;
         max_d    = '0;
         cand_d   = '0;
         empate_d = 1'b0;
         morte_d  = 1'b0;
         morto_d  = '0;
         inval_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q     <= OCIOSO;
         cnt_q    <= '0;
         vivos_q  <= '1;
         tally_q  <= '0;
         prot_q   <= '0;
         prot_v_q <= 1'b0;
         feito_q  <= 1'b0;
         idx_q    <= '0;
         max_q    <= '0;
         cand_q   <= '0;
         empate_q <= 1'b0;
         morte_q  <= 1'b0;
         morto_q  <= '0;
         inval_q  <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         vivos_q  <= vivos_d;
         tally_q  <= tally_d;
         prot_q   <= prot_d;
         prot_v_q <= prot_v_d;
         feito_q  <= feito_d;
         idx_q    <= idx_d;
         max_q    <= max_d;
         cand_q   <= cand_d;
         empate_q <= empate_d;
         morte_q  <= morte_d;
         morto_q  <= morto_d;
         inval_q  <= inval_d;
      end
   end

   assign bus.jogador_atual = cnt_q;
   assign bus.CJ_fim        = (cnt_q == ULTIMO);
   assign bus.jogador_vivo  = vivos_q[cnt_q];
   assign bus.vivos         = vivos_q;
   assign bus.acao_invalida = inval_q;
   assign bus.ocupado       = (st_q != OCIOSO);
   assign bus.morte_valida  = morte_q;
   assign bus.morto_id      = morto_q;
endmodule
